alu_op_sequencer: RTL and testbench

// Issuing side of the ALU interface: accepts 16-bit instructions over a valid/ready handshake,

---
 rtl/alu_op_sequencer.sv | 174 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Issue side of an external combinational ALU. It accepts one 16-bit
//   instruction at a time over a valid/ready handshake and owns an 8-entry
//   register file. Operands and op are presented to the ALU from registers.
//   The ALU result and zero flag are captured, then the result is written back.
//
//   Instruction word: [15:14] class, [12:11] aluop, [10:8] rd, [7:5] rn,
//   [4:3] shift, [2:0] rm, [7:0] imm8.
//   Class 00 MOV, 01 ALU, 10 CMP (flags only), 11 reserved (flags illegal).
//
//   Optional macro ALU_SEQ_SHIFT_EN: when defined, operand B is shifted by
//   instr[4:3] (none/LSL1/LSR1/ASR1) as it is loaded.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   instr_valid/ready     instruction handshake; ready only while idle
//   instr                 instruction word
//   alu_ain/bin/op        registered ALU operands and opcode
//   alu_out, alu_z        combinational ALU result and zero flag
//   done, illegal         one-cycle retire pulse; illegal marks reserved class
//   z_flag                sticky Z from the last ALU/CMP instruction
//   dbg_addr, dbg_data    combinational register file read port
module alu_op_sequencer #(
  parameter int DATA_W     = 16,
  parameter bit RESET_REGS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [DATA_W-1:0] alu_ain,
  output logic [DATA_W-1:0] alu_bin,
  output logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_z,
  output logic              done,
  output logic              illegal,
  output logic              z_flag,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [2:0] {IDLE, RDA, RDB, EXEC, WB} state_t;

  state_t              state_q, state_d;
  logic [1:0]          cls_q, cls_d;
  logic [2:0]          rd_q, rd_d;
  logic [7:0]          imm_q, imm_d;   // also carries rn/shift/rm
  logic [DATA_W-1:0]   ain_q, ain_d;
  logic [DATA_W-1:0]   bin_q, bin_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                z_flag_q, z_flag_d;
  logic [DATA_W-1:0]   regs_q [8];
  logic [DATA_W-1:0]   regs_d [8];
  logic [DATA_W-1:0]   rm_val;

  // Bit 13 has no meaning in any instruction class.
  logic unused_instr_bit;
  assign unused_instr_bit = instr[13];

  assign rm_val = regs_q[imm_q[2:0]];

  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    ain_d    = ain_q;
    bin_d    = bin_q;
    op_d     = op_q;
    res_d    = res_q;
    z_flag_d = z_flag_q;
    regs_d   = regs_q;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          cls_d = instr[15:14];
          rd_d  = instr[10:8];
          imm_d = instr[7:0];
          if (instr[15:14] == 2'b01 || instr[15:14] == 2'b10) begin
            op_d    = instr[12:11];
            state_d = RDA;
          end else begin
            state_d = WB;
          end
        end
      end
      RDA: begin
        ain_d   = regs_q[imm_q[7:5]];
        state_d = RDB;
      end
      RDB: begin
`ifdef ALU_SEQ_SHIFT_EN
        case (imm_q[4:3])
          2'b01:   bin_d = {rm_val[DATA_W-2:0], 1'b0};
          2'b10:   bin_d = {1'b0, rm_val[DATA_W-1:1]};
          2'b11:   bin_d = {rm_val[DATA_W-1], rm_val[DATA_W-1:1]};
          default: bin_d = rm_val;
        endcase
`else
        bin_d = rm_val;
`endif
        state_d = EXEC;
      end
      EXEC: begin
        res_d    = alu_out;
        z_flag_d = alu_z;
        state_d  = WB;
      end
      WB: begin
        // CMP and reserved retire without touching the register file.
        if (cls_q == 2'b00)
          regs_d[rd_q] = {{(DATA_W-8){imm_q[7]}}, imm_q};
        else if (cls_q == 2'b01)
          regs_d[rd_q] = res_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cls_q    <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      ain_q    <= '0;
      bin_q    <= '0;
      op_q     <= '0;
      res_q    <= '0;
      z_flag_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
      ain_q    <= ain_d;
      bin_q    <= bin_d;
      op_q     <= op_d;
      res_q    <= res_d;
      z_flag_q <= z_flag_d;
    end
  end

  // Reset forces IDLE, so an in-flight write-back is dropped in both variants.
  generate
    if (RESET_REGS) begin : g_regs_rst
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else begin
          regs_q <= regs_d;
        end
      end
    end else begin : g_regs_norst
      always_ff @(posedge clk) begin
        regs_q <= regs_d;
      end
    end
  endgenerate

  assign instr_ready = (state_q == IDLE);
  assign done        = (state_q == WB);
  assign illegal     = (state_q == WB) && (cls_q == 2'b11);
  assign alu_ain     = ain_q;
  assign alu_bin     = bin_q;
  assign alu_op      = op_q;
  assign z_flag      = z_flag_q;
  assign dbg_data    = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] alu_ain, alu_bin, alu_out;
  logic [1:0]  alu_op;
  logic        alu_z, done, illegal, z_flag;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DATA_W(16), .RESET_REGS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_ain(alu_ain), .alu_bin(alu_bin), .alu_op(alu_op),
    .alu_out(alu_out), .alu_z(alu_z), .done(done), .illegal(illegal),
    .z_flag(z_flag), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // External combinational ALU
  always_comb begin
    case (alu_op)
      2'b00:   alu_out = alu_ain + alu_bin;
      2'b01:   alu_out = alu_ain - alu_bin;
      2'b10:   alu_out = alu_ain & alu_bin;
      default: alu_out = ~alu_bin;
    endcase
    alu_z = (alu_out == 16'h0000);
  end

  // Architectural reference model: what each instruction must do and when it
  // must retire, counted in cycles from acceptance.
  logic [15:0] m_regs [8];
  logic        m_z;
  logic [1:0]  m_op, m_cls;
  logic [2:0]  m_rd;
  logic [15:0] m_wdata;
  logic        m_zn;
  int          m_cnt = 0;
  int          m_acc = 0;

  function automatic logic [15:0] m_shift(input logic [15:0] v, input logic [1:0] sh);
`ifdef ALU_SEQ_SHIFT_EN
    case (sh)
      2'b01:   return v << 1;
      2'b10:   return v >> 1;
      2'b11:   return 16'($signed(v) >>> 1);
      default: return v;
    endcase
`else
    if (sh == 2'b11) return v;  // shift field has no effect in this build
    return v;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_z = 1'b0; m_op = 2'b00; m_cls = 2'b00;
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    end else begin
      if (m_cnt == 2) m_z = m_zn;
      if (m_cnt == 1 && (m_cls == 2'b00 || m_cls == 2'b01)) m_regs[m_rd] = m_wdata;
      if (m_cnt != 0) m_cnt--;
      else if (instr_valid) begin
        logic [15:0] a, b;
        m_cls = instr[15:14];
        m_rd  = instr[10:8];
        m_acc++;
        if (m_cls == 2'b00) begin
          m_wdata = {{8{instr[7]}}, instr[7:0]};
          m_cnt = 1;
        end else if (m_cls == 2'b11) begin
          m_cnt = 1;
        end else begin
          a = m_regs[instr[7:5]];
          b = m_shift(m_regs[instr[2:0]], instr[4:3]);
          case (instr[12:11])
            2'b00:   m_wdata = a + b;
            2'b01:   m_wdata = a - b;
            2'b10:   m_wdata = a & b;
            default: m_wdata = ~b;
          endcase
          m_zn  = (m_wdata == 16'h0000);
          m_op  = instr[12:11];
          m_cnt = 4;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of the handshake/retire/flag outputs against the model.
  always @(negedge clk) begin
    chk("ready", 32'(instr_ready), 32'(m_cnt == 0));
    chk("done", 32'(done), 32'(m_cnt == 1));
    chk("illegal", 32'(illegal), 32'(m_cnt == 1 && m_cls == 2'b11));
    chk("z_flag", 32'(z_flag), 32'(m_z));
    chk("alu_op", 32'(alu_op), 32'(m_op));
  end

  function automatic logic [15:0] f_mov(input logic [2:0] rd, input logic [7:0] imm);
    return {5'b00000, rd, imm};
  endfunction

  function automatic logic [15:0] f_alu(input logic [1:0] cls, input logic [1:0] op,
                                        input logic [2:0] rd, input logic [2:0] rn,
                                        input logic [1:0] sh, input logic [2:0] rm);
    return {cls, 1'b0, op, rd, rn, sh, rm};
  endfunction

  // Issue one instruction, check retire latency and illegal, end idle.
  task automatic issue(input logic [15:0] w, input int lat, input logic ill);
    int a0, n;
    @(negedge clk);
    instr = w; instr_valid = 1'b1; a0 = m_acc; n = 0;
    while (m_acc == a0 && n < 50) begin @(negedge clk); n++; end
    instr_valid = 1'b0;
    if (m_acc == a0) chk("accept_timeout", 32'd0, 32'd1);
    n = 1;
    while (!done && n < 20) begin @(negedge clk); n++; end
    chk("latency", 32'(n), 32'(lat));
    chk("illegal_at_done", 32'(illegal), 32'(ill));
    @(negedge clk);
  endtask

  // Literal expectation, pinned against both the DUT and the model.
  task automatic chk_reg(input logic [2:0] idx, input logic [15:0] exp);
    dbg_addr = idx; #1;
    chk($sformatf("R%0d", idx), 32'(dbg_data), 32'(exp));
    chk($sformatf("model_R%0d", idx), 32'(m_regs[idx]), 32'(exp));
  endtask

  task automatic chk_all_regs();
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i); #1;
      chk($sformatf("regfile_R%0d", i), 32'(dbg_data), 32'(m_regs[i]));
    end
  endtask

  initial begin
    int a0, n;
    rst_n = 1'b0; instr_valid = 1'b0; instr = 16'h0000; dbg_addr = 3'd0;
    #23 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_z", 32'(z_flag), 32'd0);
    chk("rst_ain", 32'(alu_ain), 32'd0);
    chk("rst_bin", 32'(alu_bin), 32'd0);
    chk_reg(3'd0, 16'h0000);

    // 1: MOV / MOV / ADD
    issue(f_mov(3'd0, 8'h05), 1, 1'b0);
    issue(f_mov(3'd1, 8'hFD), 1, 1'b0);
    issue(f_alu(2'b01, 2'b00, 3'd2, 3'd0, 2'b00, 3'd1), 4, 1'b0);
    chk_reg(3'd1, 16'hFFFD);
    chk_reg(3'd2, 16'h0002);
    chk("t1_z", 32'(z_flag), 32'd0);

    // 2: SUB to zero, then CMP AND
    issue(f_alu(2'b01, 2'b01, 3'd3, 3'd0, 2'b00, 3'd0), 4, 1'b0);
    chk_reg(3'd3, 16'h0000);
    chk("t2_z_sub", 32'(z_flag), 32'd1);
    issue(f_alu(2'b10, 2'b10, 3'd3, 3'd0, 2'b00, 3'd1), 4, 1'b0);
    chk("t2_z_cmp", 32'(z_flag), 32'd0);
    chk_reg(3'd3, 16'h0000);

    // 3: NOT and aliased ADD
    issue(f_alu(2'b01, 2'b11, 3'd4, 3'd0, 2'b00, 3'd1), 4, 1'b0);
    chk_reg(3'd4, 16'h0002);
    issue(f_alu(2'b01, 2'b00, 3'd0, 3'd0, 2'b00, 3'd0), 4, 1'b0);
    chk_reg(3'd0, 16'h000A);

    // 5: reserved class leaves state alone (set z=1 first so it shows)
    issue(f_alu(2'b10, 2'b01, 3'd0, 3'd0, 2'b00, 3'd0), 4, 1'b0);
    chk("t5_z_pre", 32'(z_flag), 32'd1);
    issue(16'hC000, 1, 1'b1);
    chk("t5_z_post", 32'(z_flag), 32'd1);
    chk_reg(3'd0, 16'h000A);
    chk_reg(3'd4, 16'h0002);

    // 5 cont: valid held high while busy
    @(negedge clk);
    instr = f_alu(2'b01, 2'b00, 3'd6, 3'd0, 2'b00, 3'd4); instr_valid = 1'b1;
    a0 = m_acc; n = 0;
    while (m_acc == a0 && n < 50) begin @(negedge clk); n++; end
    instr = f_mov(3'd7, 8'h07);
    a0 = m_acc; n = 0;
    while (m_acc == a0 && n < 50) begin @(negedge clk); n++; end
    instr_valid = 1'b0;
    chk("held_gap", 32'(n), 32'd5);
    n = 0;
    while (m_cnt != 0 && n < 20) begin @(negedge clk); n++; end
    chk_reg(3'd6, 16'h000C);
    chk_reg(3'd7, 16'h0007);

    // 4: reset during EXEC drops the write-back
    @(negedge clk);
    instr = f_alu(2'b01, 2'b00, 3'd5, 3'd0, 2'b00, 3'd1); instr_valid = 1'b1;
    @(negedge clk); instr_valid = 1'b0;     // RDA
    @(negedge clk);                         // RDB
    @(negedge clk);                         // EXEC
    #2 rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("t4_ready", 32'(instr_ready), 32'd1);
    chk_reg(3'd5, 16'h0000);
    chk_reg(3'd0, 16'h0000);

    // 6: build R1=0x8004, then ADD R3,R0,R1 with shift=11
    issue(f_mov(3'd1, 8'h80), 1, 1'b0);
    for (int k = 0; k < 8; k++)
      issue(f_alu(2'b01, 2'b00, 3'd1, 3'd1, 2'b00, 3'd1), 4, 1'b0);
    issue(f_mov(3'd2, 8'h04), 1, 1'b0);
    issue(f_alu(2'b01, 2'b00, 3'd1, 3'd1, 2'b00, 3'd2), 4, 1'b0);
    chk_reg(3'd1, 16'h8004);
    issue(f_mov(3'd0, 8'h00), 1, 1'b0);
    issue(f_alu(2'b01, 2'b00, 3'd3, 3'd0, 2'b11, 3'd1), 4, 1'b0);
`ifdef ALU_SEQ_SHIFT_EN
    chk_reg(3'd3, 16'hC002);
`else
    chk_reg(3'd3, 16'h8004);
`endif
    chk_all_regs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

endmodule
